// File: rtl/grs_round_pipe_pkg.sv
// Shared definitions for the GRS rounding pipeline: rounding-mode encodings
// and the legal-mode check used to flag unsupported modes.
package grs_round_pipe_pkg;

    typedef enum logic [2:0] {
        MODE_RNE = 3'd0,
        MODE_RTZ = 3'd1,
        MODE_RPI = 3'd2,
        MODE_RNI = 3'd3,
        MODE_RNA = 3'd4
    } grs_mode_e;

    function automatic logic mode_legal(input logic [2:0] mode);
        logic legal;
        case (mode)
            MODE_RNE, MODE_RTZ, MODE_RPI, MODE_RNI, MODE_RNA: legal = 1'b1;
            default:                                          legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/grs_round_pipe_reg.sv
// One valid/ready register slice; the payload only loads on an accepted beat
// so it stays put while the downstream side stalls.
module grs_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_r;
    logic [W-1:0] data_r;

    assign in_ready  = ~valid_r | out_ready;
    assign out_valid = valid_r;
    assign out_data  = data_r;

    // Slice occupancy and payload capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= {W{1'b0}};
        end else if (in_ready) begin
            valid_r <= in_valid;
            if (in_valid) begin
                data_r <= in_data;
            end
        end
    end

endmodule

// File: rtl/grs_round_pipe_round.sv
// Rounding decision: takes the kept LSB plus guard/round/sticky bits and the
// sign, and decides whether the truncated magnitude must be incremented.
module grs_round
    import grs_round_pipe_pkg::*;
(
    input  logic [2:0] mode,
    input  logic       lsb,
    input  logic       g,
    input  logic       r,
    input  logic       s,
    input  logic       sign,
    output logic       inc,
    output logic       inexact
);

    // Increment decision per rounding mode; unsupported codes never round up.
    always_comb begin
        inexact = g | r | s;
        inc     = 1'b0;
        case (mode)
            MODE_RNE: inc = g & (lsb | r | s);
            MODE_RTZ: inc = 1'b0;
            MODE_RPI: inc = ~sign & (g | r | s);
            MODE_RNI: inc = sign & (g | r | s);
            MODE_RNA: inc = g;
            default:  inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/grs_round_pipe.sv
// Two-stage flow-controlled rounding stage: stage 1 holds the rounding
// decision, stage 2 holds the renormalised result; plus an inexact counter.
module grs_round_pipe
    import grs_round_pipe_pkg::*;
#(
    parameter int IN_W  = 28,
    parameter int OUT_W = 24,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_value,
    input  logic             in_sign,
    input  logic [2:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_value,
    output logic             out_carry,
    output logic             out_inexact,
    output logic             out_mode_err,
    output logic             out_sign,
    output logic [TAG_W-1:0] out_tag,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_inexact
);

    localparam int SH = IN_W - OUT_W;
    localparam int PW = OUT_W + 4 + TAG_W;

    if (IN_W < OUT_W + 1) begin : g_width_check
        $error("grs_round_pipe: IN_W must be at least OUT_W+1");
    end

    logic [OUT_W-1:0] base_s;
    logic             g_s;
    logic             r_s;
    logic             s_s;
    logic             inc_s;
    logic             inexact_s;
    logic             mode_err_s;

    assign base_s     = in_value[IN_W-1:SH];
    assign g_s        = in_value[SH-1];
    assign mode_err_s = ~mode_legal(in_mode);

    if (SH >= 2) begin : g_round_bit
        assign r_s = in_value[SH-2];
    end else begin : g_no_round_bit
        assign r_s = 1'b0;
    end

    if (SH >= 3) begin : g_sticky
        assign s_s = |in_value[SH-3:0];
    end else begin : g_no_sticky
        assign s_s = 1'b0;
    end

    grs_round u_round (
        .mode    (in_mode),
        .lsb     (base_s[0]),
        .g       (g_s),
        .r       (r_s),
        .s       (s_s),
        .sign    (in_sign),
        .inc     (inc_s),
        .inexact (inexact_s)
    );

    logic [PW-1:0] s1_in_s;
    logic [PW-1:0] s1_out_s;
    logic          s1_valid_s;
    logic          s2_ready_s;

    assign s1_in_s = {base_s, inc_s, inexact_s, mode_err_s, in_sign, in_tag};

    grs_pipe_reg #(.W(PW)) u_stage1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in_s),
        .out_valid (s1_valid_s),
        .out_ready (s2_ready_s),
        .out_data  (s1_out_s)
    );

    logic [OUT_W-1:0] s1_base_s;
    logic             s1_inc_s;
    logic [OUT_W:0]   sum_s;
    logic [OUT_W-1:0] value_s;
    logic             carry_s;
    logic [PW-1:0]    s2_in_s;
    logic [PW-1:0]    s2_out_s;

    assign s1_base_s = s1_out_s[PW-1 -: OUT_W];
    assign s1_inc_s  = s1_out_s[TAG_W+3];
    assign sum_s     = {1'b0, s1_base_s} + {{OUT_W{1'b0}}, s1_inc_s};

    // A carry out of the kept field renormalises to the leading-one pattern.
    always_comb begin
        carry_s = sum_s[OUT_W];
        if (sum_s[OUT_W]) begin
            value_s = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            value_s = sum_s[OUT_W-1:0];
        end
    end

    assign s2_in_s = {value_s, carry_s, s1_out_s[TAG_W+2:0]};

    grs_pipe_reg #(.W(PW)) u_stage2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid_s),
        .in_ready  (s2_ready_s),
        .in_data   (s2_in_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_out_s)
    );

    assign out_value    = s2_out_s[PW-1 -: OUT_W];
    assign out_carry    = s2_out_s[TAG_W+3];
    assign out_inexact  = s2_out_s[TAG_W+2];
    assign out_mode_err = s2_out_s[TAG_W+1];
    assign out_sign     = s2_out_s[TAG_W];
    assign out_tag      = s2_out_s[TAG_W-1:0];

    logic [CNT_W-1:0] cnt_r;

    assign cnt_inexact = cnt_r;

    // Saturating count of delivered inexact beats; clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (out_valid && out_ready && out_inexact && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_grs_round_pipe.sv
// Directed bench for grs_round_pipe: a scoreboard queue fed from a rounding
// model at input handshakes and drained at output handshakes.
module tb_grs_round_pipe;
    import grs_round_pipe_pkg::*;

    typedef struct packed {
        logic [23:0] v;
        logic        c;
        logic        ix;
        logic        me;
        logic        sg;
        logic [7:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_sign, out_ready, cnt_clr;
    logic [27:0] in_value;
    logic [2:0]  in_mode;
    logic [7:0]  in_tag;
    logic        in_ready, out_valid, out_carry, out_inexact, out_mode_err, out_sign;
    logic [23:0] out_value;
    logic [7:0]  out_tag;
    logic [15:0] cnt_inexact;
    logic        in_ready2, out_valid2, out_carry2, out_inexact2, out_mode_err2, out_sign2;
    logic [23:0] out_value2;
    logic [7:0]  out_tag2;
    logic [1:0]  cnt_inexact2;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   acc_base;
    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;

    grs_round_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .in_sign(in_sign), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
        .out_carry(out_carry), .out_inexact(out_inexact), .out_mode_err(out_mode_err),
        .out_sign(out_sign), .out_tag(out_tag), .cnt_clr(cnt_clr), .cnt_inexact(cnt_inexact)
    );

    grs_round_pipe #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_value(in_value), .in_sign(in_sign), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid2), .out_ready(out_ready), .out_value(out_value2),
        .out_carry(out_carry2), .out_inexact(out_inexact2), .out_mode_err(out_mode_err2),
        .out_sign(out_sign2), .out_tag(out_tag2), .cnt_clr(cnt_clr), .cnt_inexact(cnt_inexact2)
    );

    // Reference rounding: compare the 4 discarded bits against the half-way point.
    function automatic exp_t model(logic [27:0] v, logic s, logic [2:0] m, logic [7:0] t);
        exp_t        r;
        logic [23:0] base;
        logic [3:0]  rem;
        logic        inc;
        logic [24:0] sum;
        base = v[27:4];
        rem  = v[3:0];
        case (m)
            3'd0:    inc = (rem > 4'd8) || ((rem == 4'd8) && base[0]);
            3'd1:    inc = 1'b0;
            3'd2:    inc = !s && (rem != 4'd0);
            3'd3:    inc = s && (rem != 4'd0);
            3'd4:    inc = (rem >= 4'd8);
            default: inc = 1'b0;
        endcase
        sum   = {1'b0, base} + {24'd0, inc};
        r.c   = (sum == 25'h1000000);
        r.v   = r.c ? 24'h800000 : sum[23:0];
        r.ix  = (rem != 4'd0);
        r.me  = (m > 3'd4);
        r.sg  = s;
        r.tag = t;
        return r;
    endfunction

    // Scoreboard: push at input handshake, pop and compare at output handshake.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_vec++;
                assert (q.size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_beat got tag=%h exp=none", out_tag);
                end
                if (q.size() != 0) begin
                    e = q.pop_front();
                    assert ({out_value, out_carry, out_inexact, out_mode_err, out_sign, out_tag} === e)
                    else begin
                        n_err++;
                        $error("FAIL beat_t%h got v=%h c=%b ix=%b me=%b sg=%b tag=%h exp v=%h c=%b ix=%b me=%b sg=%b tag=%h",
                               e.tag, out_value, out_carry, out_inexact, out_mode_err, out_sign, out_tag,
                               e.v, e.c, e.ix, e.me, e.sg, e.tag);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_value, in_sign, in_mode, in_tag));
                n_acc++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one beat from posedge+1 and hold it until accepted.
    task automatic send(input logic [27:0] v, input logic s, input logic [2:0] m, input logic [7:0] t);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_value = v;
        in_sign  = s;
        in_mode  = m;
        in_tag   = t;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        chk("send_accept", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_value = 28'($urandom);
        in_mode  = 3'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        chk("drain_empty", q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_value  = 28'd0;
        in_sign   = 1'b0;
        in_mode   = 3'd0;
        in_tag    = 8'd0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_cnt", {16'd0, cnt_inexact}, 32'd0);
        chk("rst_value", {8'd0, out_value}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // RNE ties, mode sweep, carry and exact cases.
        send(28'h0000018, 1'b0, MODE_RNE, 8'h01);
        send(28'h0000028, 1'b0, MODE_RNE, 8'h02);
        send(28'h0000028, 1'b1, MODE_RNA, 8'h03);
        send(28'h0000028, 1'b1, MODE_RTZ, 8'h04);
        send(28'h0000028, 1'b1, MODE_RPI, 8'h05);
        send(28'h0000028, 1'b1, MODE_RNI, 8'h06);
        send(28'h0000028, 1'b1, 3'b111,   8'h07);
        send(28'hFFFFFFF, 1'b0, MODE_RNE, 8'h08);
        send(28'h0000010, 1'b0, MODE_RNE, 8'h09);
        send(28'h0000027, 1'b0, MODE_RPI, 8'h0A);
        drain();

        // Backpressure: four back-to-back beats against a stalled output.
        out_ready = 1'b0;
        acc_base  = n_acc;
        fork
            begin
                send(28'h0000123, 1'b0, MODE_RNE, 8'h11);
                send(28'h0000458, 1'b1, MODE_RNA, 8'h12);
                send(28'h0000789, 1'b1, MODE_RNI, 8'h13);
                send(28'h0000ABC, 1'b0, MODE_RTZ, 8'h14);
            end
            begin
                repeat (5) @(negedge clk);
                chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
                chk("bp_accepted", n_acc - acc_base, 32'd2);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_total", n_acc - acc_base, 32'd4);

        // Counter: 3 inexact plus 1 exact, then saturation of the 2-bit copy.
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        send(28'h0000011, 1'b0, MODE_RNE, 8'h21);
        send(28'h0000020, 1'b0, MODE_RNE, 8'h22);
        send(28'h000001F, 1'b0, MODE_RTZ, 8'h23);
        send(28'h0000038, 1'b0, MODE_RNE, 8'h24);
        drain();
        chk("cnt_three", {16'd0, cnt_inexact}, 32'd3);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) send(28'h0000101 + 28'(i), 1'b0, MODE_RNE, 8'h30 + 8'(i));
        drain();
        chk("cnt_five", {16'd0, cnt_inexact}, 32'd5);
        chk("cnt_sat", {30'd0, cnt_inexact2}, 32'd3);

        // Clear in the same cycle as an inexact delivery.
        out_ready = 1'b0;
        send(28'h0000205, 1'b0, MODE_RNE, 8'h40);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        chk("clr_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        cnt_clr   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("clr_priority", {16'd0, cnt_inexact}, 32'd0);
        chk("clr_priority2", {30'd0, cnt_inexact2}, 32'd0);

        // Reset with both stages full and the output stalled.
        send(28'h0000307, 1'b0, MODE_RNE, 8'h50);
        drain();
        out_ready = 1'b0;
        send(28'h0000409, 1'b1, MODE_RNA, 8'h51);
        send(28'h000050B, 1'b0, MODE_RPI, 8'h52);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst2_cnt", {16'd0, cnt_inexact}, 32'd0);
        chk("rst2_tag", {24'd0, out_tag}, 32'd0);
        chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);

        // First beat after release: valid exactly two cycles after handshake.
        out_ready = 1'b1;
        send(28'h000060C, 1'b0, MODE_RNE, 8'h60);
        @(negedge clk);
        chk("lat_cycle1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_cycle2", {31'd0, out_valid}, 32'd1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/grs_round_pipe.md
# grs_round_pipe

Pipelined, flow-controlled rounding stage that takes an unrounded `IN_W`-bit magnitude, applies a per-beat selectable rounding mode, and returns the `OUT_W`-bit rounded magnitude. It also reports mantissa carry-out (for exponent adjust), an inexact flag and an illegal-mode flag. The block sits between the normaliser and the exponent-adjust/pack stage of every FP datapath (add, mul, convert), replacing the bare increment decision plus external adder. It has valid/ready on both sides, a sideband tag, and a saturating inexact-event counter.

## Interface
- `IN_W`, 28: unrounded input width; must satisfy `IN_W >= OUT_W+1` (elaboration error otherwise).
- `OUT_W`, 24: rounded output width.
- `TAG_W`, 8: opaque sideband width, carried unchanged with each beat.
- `CNT_W`, 16: inexact-event counter width.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block accepts the beat this cycle.
- `in_value`  in  IN_W  unrounded magnitude, MSB-aligned.
- `in_sign`  in  1  sign of the value (used by the directed modes only).
- `in_mode`  in  3  rounding mode, with encodings RNE/RTZ/RPI/RNI/RNA from the shared header.
- `in_tag`  in  TAG_W  sideband.
- `out_valid`  out  1  output beat present.
- `out_ready`  in  1  downstream accepts.
- `out_value`  out  OUT_W  rounded magnitude.
- `out_carry`  out  1  rounding overflowed `OUT_W` bits.
- `out_inexact`  out  1  any discarded bit was non-zero.
- `out_mode_err`  out  1  `in_mode` was not one of the five legal codes.
- `out_sign`, `out_tag`  out  1, TAG_W  passed through.
- `cnt_clr`  in  1  synchronous clear of the counter.
- `cnt_inexact`  out  CNT_W  saturating count of inexact beats delivered.

## Operation
- Truncation point is `SH = IN_W-OUT_W`. Base = `in_value[IN_W-1:SH]`. G = bit `SH-1`. R = bit `SH-2` (0 if `SH<2`). S = OR of bits `SH-3..0` (0 if `SH<3`). Inexact = G|R|S.
- Increment rules:
  - RNE: G&(L|R|S).
  - RTZ: 0.
  - RPI: !sign&inexact.
  - RNI: sign&inexact.
  - RNA: G.
  - Illegal mode: 0, with `out_mode_err`=1.
- Stage 1 registers base, the increment bit, inexact, mode_err, sign and tag.
- Stage 2 computes the `OUT_W+1`-bit sum base+inc.
  - If bit `OUT_W` is set: `out_carry`=1 and `out_value` = 1 followed by `OUT_W-1` zeros (renormalised).
  - Otherwise `out_carry`=0 and `out_value` = sum[OUT_W-1:0].
- Counter: increments by 1 on each output handshake (`out_valid&out_ready`) with `out_inexact`=1. It saturates at all-ones. `cnt_clr` has priority over an increment in the same cycle.

## Timing
- Latency: 2 cycles from input handshake to `out_valid` when not stalled. Throughput is 1 beat/cycle.
- Stage 2 advances when it is empty or `out_ready`=1. Stage 1 advances when it is empty or stage 2 advances. `in_ready` = stage 1 empty or stage 1 advancing.
- The combinational path `out_ready`→`in_ready` is permitted.
- `out_*` data is held stable while `out_valid`=1 and `out_ready`=0. No beat is dropped or duplicated.
- Reset (any cycle, including mid-stall):
  - next-cycle `out_valid`=0 and `cnt_inexact`=0;
  - `out_value`, `out_carry`, `out_inexact`, `out_mode_err`, `out_sign`, `out_tag` = 0;
  - in-flight beats are discarded;
  - `in_ready`=1 in the first cycle after reset deasserts.
- `in_value` is sampled only on a handshake. Values on the inputs without `in_valid` have no effect.

## Structure
- Shared header `grs_round.vh`: mode encodings (already exists), plus a `GRS_MODE_LEGAL` check macro added here.
- The stage-1 decision instantiates the existing `grs_round` combinational module. Illegal-mode detection is local.
- One natural sub-module: `grs_pipe_reg`, a valid/ready register slice with payload width parameter, used for both stages.

## Test plan
(All with `IN_W`=28, `OUT_W`=24.)
- RNE ties: `in_value`=0x0000018 (L=1, G=1) → `out_value`=0x000002, inexact=1. `in_value`=0x0000028 (L=0, G=1) → 0x000002.
- Mode sweep on `in_value`=0x0000028, sign=1:
  - RNA → 0x000003;
  - RTZ → 0x000002;
  - RPI → 0x000002;
  - RNI → 0x000003;
  - mode 3'b111 → 0x000002 with `out_mode_err`=1.
- Carry: `in_value`=0xFFFFFFF, RNE → `out_value`=0x800000, `out_carry`=1. Exact input 0x0000010 → inexact=0, `out_value`=0x000001.
- Backpressure: 4 back-to-back beats with `out_ready`=0 for 5 cycles → `in_ready` drops after 2 accepted. All 4 beats emerge in order with their tags; no loss or duplication.
- Counter: 3 inexact plus 1 exact beats delivered → `cnt_inexact`=3. With `CNT_W`=2, 5 inexact beats → 3 (saturated). `cnt_clr` in the same cycle as a delivery → 0.
- Reset asserted with both stages full and the output stalled → next cycle `out_valid`=0 and counter=0. The first beat after release has latency 2.
